// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU command sequencer: opcodes, cmd_flags bit
// positions and the issue FSM state encoding.
package alsu_pkg;

  localparam logic [2:0] OP_AND       = 3'b000;
  localparam logic [2:0] OP_XOR       = 3'b001;
  localparam logic [2:0] OP_ADD       = 3'b010;
  localparam logic [2:0] OP_MULT      = 3'b011;
  localparam logic [2:0] OP_SHIFT     = 3'b100;
  localparam logic [2:0] OP_ROTATE    = 3'b101;
  localparam logic [2:0] OP_INVALID_6 = 3'b110;
  localparam logic [2:0] OP_INVALID_7 = 3'b111;

  // cmd_flags is {cin, SI, sh_left, red_op_A, red_op_B, pass_A, pass_B}
  localparam int FLAG_CIN      = 6;
  localparam int FLAG_SI       = 5;
  localparam int FLAG_SH_LEFT  = 4;
  localparam int FLAG_RED_OP_A = 3;
  localparam int FLAG_RED_OP_B = 2;
  localparam int FLAG_PASS_A   = 1;
  localparam int FLAG_PASS_B   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } seq_state_e;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SHIFT) || (op == OP_ROTATE);
  endfunction

endpackage

// File: rtl/alsu_cmd_seq_if.sv
// Bundle of the command-side handshake and the ALSU-side outputs of the
// sequencer; the sequencer uses the slave view, its driver the master view.
interface alsu_cmd_seq_if #(
  parameter int BITS  = 3,
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_opcode;
  logic [BITS-1:0]  cmd_A;
  logic [BITS-1:0]  cmd_B;
  logic [6:0]       cmd_flags;
  logic [CNT_W-1:0] cmd_rpt;

  logic [2:0]       opcode;
  logic [BITS-1:0]  A;
  logic [BITS-1:0]  B;
  logic             cin;
  logic             SI;
  logic             sh_left;
  logic             red_op_A;
  logic             red_op_B;
  logic             pass_A;
  logic             pass_B;
  logic             issue_valid;
  logic             busy;
  logic [CW-1:0]    fifo_count;

  modport slave (
    input  flush, cmd_valid, cmd_opcode, cmd_A, cmd_B, cmd_flags, cmd_rpt,
    output cmd_ready, opcode, A, B, cin, SI, sh_left, red_op_A, red_op_B,
           pass_A, pass_B, issue_valid, busy, fifo_count
  );

  modport master (
    output flush, cmd_valid, cmd_opcode, cmd_A, cmd_B, cmd_flags, cmd_rpt,
    input  cmd_ready, opcode, A, B, cin, SI, sh_left, red_op_A, red_op_B,
           pass_A, pass_B, issue_valid, busy, fifo_count
  );

endinterface

// File: rtl/alsu_cmd_fifo.sv
// Synchronous command FIFO with flush; the head entry is visible on o_dout
// without a read latency so the sequencer can load it on the pop edge.
module alsu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_din,
  output logic [WIDTH-1:0]       o_dout,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full  && !i_flush;
  assign w_do_pop  = i_pop  && !o_empty && !i_flush;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers are DEPTH-sized power-of-two counters, so they wrap on their own
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == FULL_LEVEL);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/alsu_cmd_seq.sv
// Queues ALSU commands and plays them onto registered ALSU inputs, holding
// shift/rotate commands for cmd_rpt extra cycles.
module alsu_cmd_seq #(
  parameter int BITS  = 3,
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  alsu_cmd_seq_if.slave bus
);

  import alsu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [BITS-1:0]  a;
    logic [BITS-1:0]  b;
    logic [6:0]       flags;
    logic [CNT_W-1:0] rpt;
  } cmd_t;

  seq_state_e       r_state;
  seq_state_e       w_next_state;
  cmd_t             r_cmd;
  cmd_t             w_head;
  cmd_t             w_in_cmd;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_push;
  logic             w_pop;
  logic             w_clear;
  logic             w_advance;
  logic             w_full;
  logic             w_empty;
  logic             w_issue_valid;
  logic [CW-1:0]    w_count;

  assign w_in_cmd = '{opcode: bus.cmd_opcode, a: bus.cmd_A, b: bus.cmd_B,
                      flags: bus.cmd_flags, rpt: bus.cmd_rpt};
  assign bus.cmd_ready = !rst && !w_full;
  assign w_push = bus.cmd_valid && bus.cmd_ready && !bus.flush;

  alsu_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (bus.flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_in_cmd),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // IDLE, the end of a plain ISSUE and the last HOLD cycle all share one
  // "advance" path: take the next queued command or fall back to idle.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_pop        = 1'b0;
    w_clear      = 1'b0;
    w_advance    = 1'b0;
    if (bus.flush) begin
      w_next_state = ST_IDLE;
      w_cnt_next   = '0;
      w_clear      = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE:  w_advance = 1'b1;
        ST_ISSUE: begin
          if (is_shift_op(r_cmd.opcode) && (r_cmd.rpt != '0)) begin
            w_cnt_next   = r_cmd.rpt;
            w_next_state = ST_HOLD;
          end else begin
            w_advance = 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_cnt > CNT_W'(1)) w_cnt_next = r_cnt - CNT_W'(1);
          else                   w_advance  = 1'b1;
        end
        default: w_advance = 1'b1;
      endcase
      if (w_advance) begin
        w_cnt_next = '0;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_ISSUE;
        end else begin
          w_clear      = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd <= '0;
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_pop)        r_cmd <= w_head;
      else if (w_clear) r_cmd <= '0;
    end
  end

  assign w_issue_valid   = (r_state != ST_IDLE);
  assign bus.issue_valid = w_issue_valid;
  assign bus.busy        = !w_empty || w_issue_valid;
  assign bus.fifo_count  = w_count;
  assign bus.opcode      = r_cmd.opcode;
  assign bus.A           = r_cmd.a;
  assign bus.B           = r_cmd.b;
  assign bus.cin         = r_cmd.flags[FLAG_CIN];
  assign bus.SI          = r_cmd.flags[FLAG_SI];
  assign bus.sh_left     = r_cmd.flags[FLAG_SH_LEFT];
  assign bus.red_op_A    = r_cmd.flags[FLAG_RED_OP_A];
  assign bus.red_op_B    = r_cmd.flags[FLAG_RED_OP_B];
  assign bus.pass_A      = r_cmd.flags[FLAG_PASS_A];
  assign bus.pass_B      = r_cmd.flags[FLAG_PASS_B];

endmodule
